// File: rtl/xvk_cam_alloc.sv
// Slot allocator and write-side controller for xvk_cam: scrubs all slots after
// reset, grants the lowest free slot per request and invalidates released slots.
module xvk_cam_alloc #(
   parameter int CAM_WIDTH = 13,
   parameter int CAM_DEPTH = 16,
   localparam int A = $clog2(CAM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alloc_valid,
   input  logic [CAM_WIDTH-1:0] alloc_key,
   output logic                 alloc_ready,
   output logic                 alloc_done,
   output logic [A-1:0]         alloc_slot,
   input  logic                 rel_valid,
   input  logic [A-1:0]         rel_slot,
   output logic                 rel_err,
   output logic                 cam_we,
   output logic [A-1:0]         cam_wr_addr,
   output logic [CAM_WIDTH-1:0] cam_din,
   output logic [CAM_DEPTH-1:0] cam_ignore,
   output logic [A:0]           occupancy,
   output logic                 full,
   output logic                 empty,
   output logic                 init_done
);

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [A:0]   DEPTH_CNT = (A+1)'(CAM_DEPTH);
   localparam logic [A-1:0] LAST_SLOT = A'(CAM_DEPTH - 1);

   state_t                 state_r, state_s;
   logic [A-1:0]           scnt_r, scnt_s;
   logic [CAM_DEPTH-1:0]   valid_r, valid_s;
   logic [A:0]             occ_s;
   logic                   full_s, empty_s, init_s;
   logic                   we_s, done_s, rel_err_s;
   logic [A-1:0]           addr_s, slot_s, free_s;
   logic [CAM_WIDTH-1:0]   din_s;
   logic [CAM_DEPTH-1:0]   ign_s;
   logic                   found_s, accept_s, rel_ok_s;

   assign alloc_ready = init_done && !full;

   // Lowest free slot, taken from the pre-release bitmap.
   always_comb begin
      free_s  = {A{1'b0}};
      found_s = 1'b0;
      for (int i = 0; i < CAM_DEPTH; i++) begin
         if (!found_s && !valid_r[i]) begin
            free_s  = A'(i);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state and registered-output values for scrub, allocate and release.
   always_comb begin
      state_s   = state_r;
      scnt_s    = scnt_r;
      valid_s   = valid_r;
      occ_s     = occupancy;
      init_s    = init_done;
      we_s      = 1'b0;
      addr_s    = cam_wr_addr;
      din_s     = cam_din;
      done_s    = 1'b0;
      slot_s    = alloc_slot;
      ign_s     = {CAM_DEPTH{1'b0}};
      accept_s  = alloc_valid && alloc_ready;
      rel_ok_s  = rel_valid && init_done && valid_r[rel_slot];
      rel_err_s = rel_valid && !rel_ok_s;

      case (state_r)
         ST_INIT: begin
            we_s   = 1'b1;
            addr_s = scnt_r;
            din_s  = {CAM_WIDTH{1'b1}};
            scnt_s = scnt_r + 1'b1;
            if (scnt_r == LAST_SLOT) begin
               state_s = ST_RUN;
               init_s  = 1'b1;
            end else begin
               state_s = ST_INIT;
            end
         end
         ST_RUN: begin
            state_s = ST_RUN;
         end
         default: begin
            state_s = ST_INIT;
         end
      endcase

      if (accept_s) begin
         valid_s[free_s] = 1'b1;
         we_s            = 1'b1;
         addr_s          = free_s;
         din_s           = alloc_key;
         done_s          = 1'b1;
         slot_s          = free_s;
      end else begin
         slot_s = alloc_slot;
      end

      // The released slot is valid, so it can never equal the granted free slot.
      if (rel_ok_s) begin
         valid_s[rel_slot] = 1'b0;
         ign_s[rel_slot]   = 1'b1;
      end else begin
         ign_s = {CAM_DEPTH{1'b0}};
      end

      case ({accept_s, rel_ok_s})
         2'b10:   occ_s = occupancy + 1'b1;
         2'b01:   occ_s = occupancy - 1'b1;
         default: occ_s = occupancy;
      endcase

      full_s  = (occ_s == DEPTH_CNT);
      empty_s = (occ_s == {(A+1){1'b0}});
   end

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_INIT;
         scnt_r      <= {A{1'b0}};
         valid_r     <= {CAM_DEPTH{1'b0}};
         alloc_done  <= 1'b0;
         alloc_slot  <= {A{1'b0}};
         rel_err     <= 1'b0;
         cam_we      <= 1'b0;
         cam_wr_addr <= {A{1'b0}};
         cam_din     <= {CAM_WIDTH{1'b1}};
         cam_ignore  <= {CAM_DEPTH{1'b0}};
         occupancy   <= {(A+1){1'b0}};
         full        <= 1'b0;
         empty       <= 1'b1;
         init_done   <= 1'b0;
      end else begin
         state_r     <= state_s;
         scnt_r      <= scnt_s;
         valid_r     <= valid_s;
         alloc_done  <= done_s;
         alloc_slot  <= slot_s;
         rel_err     <= rel_err_s;
         cam_we      <= we_s;
         cam_wr_addr <= addr_s;
         cam_din     <= din_s;
         cam_ignore  <= ign_s;
         occupancy   <= occ_s;
         full        <= full_s;
         empty       <= empty_s;
         init_done   <= init_s;
      end
   end

endmodule

// File: tb/tb_xvk_cam_alloc.sv
// Directed self-checking bench for xvk_cam_alloc (CAM_WIDTH=13, CAM_DEPTH=16).
module tb_xvk_cam_alloc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alloc_valid = 1'b0;
   logic [12:0] alloc_key = 13'h0;
   logic        alloc_ready;
   logic        alloc_done;
   logic [3:0]  alloc_slot;
   logic        rel_valid = 1'b0;
   logic [3:0]  rel_slot = 4'h0;
   logic        rel_err;
   logic        cam_we;
   logic [3:0]  cam_wr_addr;
   logic [12:0] cam_din;
   logic [15:0] cam_ignore;
   logic [4:0]  occupancy;
   logic        full, empty, init_done;

   int n_checks = 0;
   int n_fail   = 0;

   xvk_cam_alloc #(.CAM_WIDTH(13), .CAM_DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_key(alloc_key), .alloc_ready(alloc_ready),
      .alloc_done(alloc_done), .alloc_slot(alloc_slot),
      .rel_valid(rel_valid), .rel_slot(rel_slot), .rel_err(rel_err),
      .cam_we(cam_we), .cam_wr_addr(cam_wr_addr), .cam_din(cam_din),
      .cam_ignore(cam_ignore), .occupancy(occupancy),
      .full(full), .empty(empty), .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One rising edge; inputs are driven and outputs sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_values();
      chk("rst alloc_done", 32'(alloc_done), 32'd0);
      chk("rst alloc_slot", 32'(alloc_slot), 32'd0);
      chk("rst rel_err", 32'(rel_err), 32'd0);
      chk("rst cam_we", 32'(cam_we), 32'd0);
      chk("rst cam_wr_addr", 32'(cam_wr_addr), 32'd0);
      chk("rst cam_din", 32'(cam_din), 32'h1FFF);
      chk("rst cam_ignore", 32'(cam_ignore), 32'd0);
      chk("rst occupancy", 32'(occupancy), 32'd0);
      chk("rst full", 32'(full), 32'd0);
      chk("rst empty", 32'(empty), 32'd1);
      chk("rst init_done", 32'(init_done), 32'd0);
      chk("rst alloc_ready", 32'(alloc_ready), 32'd0);
   endtask

   task automatic check_scrub();
      for (int i = 0; i < 16; i++) begin
         step();
         chk("scrub we", 32'(cam_we), 32'd1);
         chk("scrub addr", 32'(cam_wr_addr), 32'(i));
         chk("scrub din", 32'(cam_din), 32'h1FFF);
         chk("scrub init_done", 32'(init_done), (i == 15) ? 32'd1 : 32'd0);
      end
      chk("post-scrub ready", 32'(alloc_ready), 32'd1);
      chk("post-scrub empty", 32'(empty), 32'd1);
      step();
      chk("post-scrub we low", 32'(cam_we), 32'd0);
   endtask

   initial begin
      // 1: reset and scrub
      #12;
      check_reset_values();
      @(negedge clk);
      rst_n = 1'b1;
      check_scrub();

      // 2: three back-to-back allocations
      alloc_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alloc_key = 13'h0A1 + 13'(i);
         step();
         chk("alloc done", 32'(alloc_done), 32'd1);
         chk("alloc slot", 32'(alloc_slot), 32'(i));
         chk("alloc wr_addr", 32'(cam_wr_addr), 32'(i));
         chk("alloc din", 32'(cam_din), 32'h0A1 + 32'(i));
      end
      chk("occ after 3", 32'(occupancy), 32'd3);
      alloc_valid = 1'b0;
      step();
      chk("idle done", 32'(alloc_done), 32'd0);
      chk("idle we", 32'(cam_we), 32'd0);
      chk("idle din held", 32'(cam_din), 32'h0A3);

      // 3: release slot 1, then re-allocate it
      rel_valid = 1'b1; rel_slot = 4'd1;
      step();
      chk("rel1 ignore", 32'(cam_ignore), 32'h0002);
      chk("rel1 occ", 32'(occupancy), 32'd2);
      rel_valid = 1'b0;
      alloc_valid = 1'b1; alloc_key = 13'h0B0;
      step();
      chk("rel1 ignore pulse", 32'(cam_ignore), 32'h0000);
      chk("realloc slot", 32'(alloc_slot), 32'd1);
      chk("realloc occ", 32'(occupancy), 32'd3);

      // 4: fill remaining slots 3..15 with the request held
      for (int i = 0; i < 13; i++) begin
         alloc_key = 13'h100 + 13'(i);
         step();
         chk("fill slot", 32'(alloc_slot), 32'(3 + i));
      end
      chk("full", 32'(full), 32'd1);
      chk("full ready", 32'(alloc_ready), 32'd0);
      chk("full occ", 32'(occupancy), 32'd16);
      step();
      chk("full no done", 32'(alloc_done), 32'd0);
      rel_valid = 1'b1; rel_slot = 4'd7;
      step();
      chk("full+rel no done", 32'(alloc_done), 32'd0);
      chk("full+rel ignore", 32'(cam_ignore), 32'h0080);
      chk("full+rel occ", 32'(occupancy), 32'd15);
      chk("full+rel ready", 32'(alloc_ready), 32'd1);
      rel_valid = 1'b0;
      step();
      chk("refill done", 32'(alloc_done), 32'd1);
      chk("refill slot", 32'(alloc_slot), 32'd7);
      chk("refill full", 32'(full), 32'd1);
      alloc_valid = 1'b0;

      // 5: release 15..5, then simultaneous release of 2 and allocate
      rel_valid = 1'b1;
      for (int s = 15; s >= 5; s--) begin
         rel_slot = 4'(s);
         step();
      end
      chk("drain occ", 32'(occupancy), 32'd5);
      rel_slot = 4'd2;
      alloc_valid = 1'b1; alloc_key = 13'h0C5;
      step();
      chk("simul slot", 32'(alloc_slot), 32'd5);
      chk("simul we", 32'(cam_we), 32'd1);
      chk("simul addr", 32'(cam_wr_addr), 32'd5);
      chk("simul ignore", 32'(cam_ignore), 32'h0004);
      chk("simul occ", 32'(occupancy), 32'd5);
      rel_valid = 1'b0; alloc_valid = 1'b0;
      step();

      // 6: illegal release of slot 9
      rel_valid = 1'b1; rel_slot = 4'd9;
      step();
      chk("bad rel err", 32'(rel_err), 32'd1);
      chk("bad rel occ", 32'(occupancy), 32'd5);
      chk("bad rel ignore", 32'(cam_ignore), 32'h0000);
      rel_valid = 1'b0;
      step();
      chk("bad rel err pulse", 32'(rel_err), 32'd0);

      // Reset mid-allocation: lowest free slot is 2
      alloc_valid = 1'b1; alloc_key = 13'h0D0;
      step();
      chk("pre-reset slot", 32'(alloc_slot), 32'd2);
      chk("pre-reset done", 32'(alloc_done), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_values();
      @(negedge clk);
      alloc_valid = 1'b0;
      rst_n = 1'b1;
      check_scrub();
      chk("post-rescrub occ", 32'(occupancy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/xvk_cam_alloc.md
# xvk_cam_alloc

Slot allocator and write-side controller for `xvk_cam`. It owns the CAM's write port (`cam_we`/`cam_wr_addr`/`cam_din`) and its `cam_ignore` vector. It scrubs every slot to the unreachable all-ones value after reset, hands out the lowest free slot per allocation request, and invalidates slots on release. The search side of the CAM (`cam_key`/`cam_se`) stays with the client; this block only guarantees that non-allocated slots never hold a matchable key.

## Interface
Parameters:
- `CAM_WIDTH`, default 13: key width; must equal the paired CAM's `CAM_WIDTH`.
- `CAM_DEPTH`, default 16: slot count, a power of two ≥ 2. `A = $clog2(CAM_DEPTH)`.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alloc_valid` in 1: allocation request.
- `alloc_key` in `CAM_WIDTH`: key to store. Must not be all-ones.
- `alloc_ready` out 1: request accepted on an edge where `alloc_valid` && `alloc_ready`.
- `alloc_done` out 1: one-cycle pulse, the cycle after acceptance.
- `alloc_slot` out `A`: slot granted; valid while `alloc_done` is high, held otherwise.
- `rel_valid` in 1: release request, single cycle, no backpressure.
- `rel_slot` in `A`: slot to release.
- `rel_err` out 1: one-cycle pulse for an illegal release.
- `cam_we`, `cam_wr_addr` [A], `cam_din` [CAM_WIDTH] out: connect to the CAM write port. All are registered.
- `cam_ignore` out `CAM_DEPTH`: connect to the CAM `cam_ignore`. Registered, one-hot pulse.
- `occupancy` out `A+1`: number of allocated slots.
- `full`, `empty` out 1: `occupancy == CAM_DEPTH` and `occupancy == 0` respectively.
- `init_done` out 1: scrub complete.

## Operation
- State machine has two states, INIT and RUN. Reset enters INIT with scrub counter `scnt` = 0.
- INIT:
  - Each edge presents `cam_we`=1, `cam_wr_addr`=`scnt`, `cam_din`=all-ones, then `scnt`++.
  - The edge that presents slot `CAM_DEPTH-1` moves the state to RUN and sets `init_done`=1.
- RUN holds until reset; there is no exit transition.
- `alloc_ready` = `init_done` && !`full` (combinational from registered state).
- `valid[CAM_DEPTH-1:0]` bitmap records allocated slots. Free slot = lowest index with `valid`=0, computed from the registered bitmap.
- Allocation accept edge:
  - Sets `valid[slot]`.
  - Registers `cam_we`=1, `cam_wr_addr`=slot, `cam_din`=`alloc_key`, `alloc_done`=1, `alloc_slot`=slot.
- No accept on an edge: `cam_we`=0 and `alloc_done`=0. `cam_wr_addr` and `cam_din` hold their values.
- Release edge, `rel_valid` with `valid[rel_slot]`=1:
  - Clears `valid[rel_slot]`.
  - Registers `cam_ignore` = one-hot(`rel_slot`) for one cycle; the CAM then overwrites that slot with all-ones.
- Release edge with `valid[rel_slot]`=0, or with `init_done`=0: `rel_err`=1 for one cycle. Bitmap, occupancy and `cam_ignore` are unchanged.
- `occupancy` update per edge: +1 on accept, −1 on legal release, unchanged when both occur.
- Simultaneous alloc and release:
  - The allocation chooses from the pre-release bitmap, so the slot being released is not grantable on that edge.
  - Write and ignore pulses therefore target different slots.
- Full with a simultaneous release: no accept on that edge. `alloc_ready` rises on the next cycle.
- Release of a slot on the edge after its allocation is legal:
  - The ignore pulse follows the write pulse by one cycle.
  - The CAM's write-over-ignore priority is never exercised.
- `alloc_key` of all-ones is a protocol violation. No check is made.

## Timing
- Reset values, asserted asynchronously while `rst_n`=0:
  - `alloc_done`=0, `alloc_slot`=0, `rel_err`=0.
  - `cam_we`=0, `cam_wr_addr`=0, `cam_din`=all-ones, `cam_ignore`=0.
  - `occupancy`=0, `full`=0, `empty`=1, `init_done`=0, `alloc_ready`=0.
  - `valid`=0, `scnt`=0.
- Scrub timing:
  - Edges E1..E`CAM_DEPTH` after `rst_n` rises present scrub writes for slots 0..`CAM_DEPTH-1`.
  - `cam_we` is high for exactly `CAM_DEPTH` consecutive cycles.
  - `init_done` and `alloc_ready` go high after E`CAM_DEPTH`.
- Allocation: accept at edge N gives `cam_we`/`alloc_done` high in cycle N+1. Throughput is one per cycle.
- Release: edge N gives `cam_ignore` pulse and `occupancy` update in cycle N+1.
- `full`/`empty` are registered alongside `occupancy`.
- Reset asserted mid-operation:
  - All state is dropped immediately.
  - Outstanding allocations are lost.
  - A full re-scrub follows deassertion.

## Test plan
1. Deassert `rst_n` with `CAM_WIDTH`=13, `CAM_DEPTH`=16:
   - `cam_we`=1 for 16 cycles with `cam_wr_addr` 0..15 and `cam_din`=13'h1FFF.
   - Then `init_done`=1, `alloc_ready`=1, `empty`=1.
2. Allocate keys 0x0A1, 0x0A2, 0x0A3 back-to-back:
   - `alloc_slot` 0, 1, 2 on consecutive `alloc_done` cycles.
   - Matching `cam_wr_addr`/`cam_din`.
   - `occupancy`=3.
3. Release slot 1, then allocate 0x0B0:
   - `cam_ignore`=16'h0002 for one cycle.
   - `alloc_slot`=1 and `occupancy` returns to 3.
4. Fill all 16 slots with `alloc_valid` held high:
   - `full`=1 and `alloc_ready`=0, with no further `alloc_done`.
   - Release slot 7 in the same cycle as the held request: no accept on that edge.
   - The next edge accepts into slot 7.
5. With slots 0–4 allocated, release slot 2 and allocate on the same edge:
   - `alloc_slot`=5, `occupancy` stays 5.
   - `cam_we` to slot 5 and `cam_ignore`=16'h0004 in the same cycle.
6. Release unoccupied slot 9 → `rel_err` pulses once, with `occupancy` and `cam_ignore` unchanged.
   - Then assert `rst_n` low mid-allocation → all outputs take their reset values immediately, and the 16-cycle scrub repeats.
